gray_sequencer: RTL
===================

GRAY_SEQUENCER -- requirements
Module: gray_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 3, code width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter DIV, default 4, idle cycles between an accepted code and the next code's valid (DIV >= 1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sequence.
REQ-006 SHALL have port stop  input  1  abort request.
REQ-007 SHALL have port dir  input  1  1 = ascending, 0 = descending; sampled only on accepted start.
REQ-008 SHALL have port mode  input  1  0 = free-run, 1 = single pass; sampled only on accepted start.
REQ-009 SHALL have port gray  output  WIDTH  current Gray code, feeding the downstream Gray-to-binary stage.
REQ-010 SHALL have port valid  output  1  gray holds a code offered downstream.
REQ-011 SHALL have port ready  input  1  downstream accepts gray this cycle.
REQ-012 SHALL have port busy  output  1  sequence in progress.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse on free-run wrap-around.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a single pass completes.

Function
REQ-015 SHALL keep an internal binary counter bin; gray SHALL be the registered value bin ^ (bin >> 1).
REQ-016 SHALL implement states IDLE, PRESENT, WAIT.
REQ-017 IDLE + start (stop low): busy=1; bin loads 0 if dir=1, else 2^WIDTH-1; enter PRESENT next cycle with valid=1.
REQ-018 PRESENT: valid=1; gray SHALL stay stable while ready=0, with no timeout.
REQ-019 PRESENT with valid && ready, not terminal: bin advances (+1 if dir, else -1, modulo 2^WIDTH); valid=0; enter WAIT.
REQ-020 WAIT SHALL last exactly DIV cycles with valid=0, then return to PRESENT with the new code.
REQ-021 Terminal code: bin = 2^WIDTH-1 ascending, bin = 0 descending.
REQ-022 Free-run transfer of the terminal code: bin wraps; wrap pulses on the following cycle.
REQ-023 Single-pass transfer of the terminal code: done pulses one cycle; enter IDLE; busy=0; valid=0.
REQ-024 stop in PRESENT or WAIT: enter IDLE next cycle; valid=0; busy=0; gray holds its last value.
REQ-025 A handshake in the same cycle as stop SHALL count as a completed transfer, with no wrap or done pulse.
REQ-026 start while busy SHALL be ignored; start and stop together in IDLE SHALL leave the block in IDLE.

Reset
REQ-027 rst SHALL force, on the next edge, state=IDLE, bin=0, gray=0, valid=0, busy=0, wrap=0, done=0, and prescaler count=0.
REQ-028 rst SHALL have priority over all other inputs, including mid-PRESENT and mid-WAIT.

Configuration
REQ-029 With macro GRAY_SEQ_BIN_MIRROR_EN defined, output bin_mirror (WIDTH bits) SHALL equal the binary of gray, registered in the same cycle and reset to 0.
REQ-030 Without GRAY_SEQ_BIN_MIRROR_EN, port bin_mirror SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Package gray_pkg SHALL hold the state enum (IDLE, PRESENT, WAIT) and function bin2gray.
REQ-032 The DIV-cycle counter SHALL be sub-module gray_tick_div, with ports clk, rst, load, and expire.

Verification (WIDTH=3, DIV=4)
REQ-033 Free-run up, ready=1: gray SHALL read 000,001,011,010,110,111,101,100,000; valid low 4 cycles between codes; wrap pulse after 100 is accepted.
REQ-034 ready=0 for 10 cycles while gray=011: valid SHALL stay 1 and gray SHALL stay 011; after ready=1, the next code 010 SHALL appear 4 cycles later.
REQ-035 Single pass down: gray SHALL read 100,101,111,110,010,011,001,000; done pulses once; busy=0; no wrap.
REQ-036 stop during WAIT after 011: next cycle valid=0 and busy=0 with gray=011; start pulses while busy SHALL be ignored.
REQ-037 rst asserted in PRESENT with gray=110: next edge, all outputs SHALL be 0; a fresh start restarts at 000.
REQ-038 With GRAY_SEQ_BIN_MIRROR_EN defined, bin_mirror SHALL track 0..7 for the REQ-033 run.

Source files
------------

// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-code sequencer:
//   state_t  : sequencer FSM states (IDLE, PRESENT, WAIT)
//   bin2gray : binary to reflected Gray conversion
// -----------------------------------------------------------------------------
package gray_pkg;

  // Widest code the helper functions handle; callers cast to/from this width.
  localparam int GRAY_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    WAIT    = 2'd2
  } state_t;

  // Reflected binary Gray code: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_tick_div.sv
// -----------------------------------------------------------------------------
// gray_tick_div
// One-shot DIV-cycle interval timer. A load starts the interval; expire is high
// during the DIV-th cycle after the load so a consumer reacting on that edge
// has seen exactly DIV cycles elapse.
//
// Parameters:
//   DIV    : interval length in cycles (DIV >= 1)
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (clears count and running flag)
//   load   : (re)start the interval
//   expire : interval complete this cycle
// -----------------------------------------------------------------------------
module gray_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_r;
  logic          active_r;

  // Down-counter: loads DIV-1, reaches zero on the DIV-th cycle, then stops.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= {CW{1'b0}};
      active_r <= 1'b0;
    end else if (load) begin
      count_r  <= CW'(DIV - 1);
      active_r <= 1'b1;
    end else if (active_r) begin
      if (count_r == {CW{1'b0}}) begin
        active_r <= 1'b0;
      end else begin
        count_r <= count_r - CW'(1);
      end
    end else begin
      count_r  <= count_r;
      active_r <= active_r;
    end
  end

  assign expire = active_r && (count_r == {CW{1'b0}});

endmodule

// File: rtl/gray_sequencer.sv
// -----------------------------------------------------------------------------
// gray_sequencer
// Steps an internal binary counter up or down and offers each value as a Gray
// code over a valid/ready handshake, with a DIV-cycle gap after each accepted
// code. Free-run mode wraps forever (wrap pulse); single-pass mode stops after
// the terminal code (done pulse). stop aborts at any time.
//
// Parameters:
//   WIDTH : code width in bits (2 <= WIDTH <= 32)
//   DIV   : idle cycles between an accepted code and the next valid (DIV >= 1)
// Ports:
//   clk, rst     : clock; synchronous active-high reset
//   start, stop  : begin a sequence (idle only) / abort
//   dir, mode    : 1=ascending/0=descending, 0=free-run/1=single pass (latched on start)
//   gray, valid  : offered code and its qualifier
//   ready        : downstream accepts gray
//   busy         : sequence in progress
//   wrap, done   : one-cycle event pulses
//   bin_mirror   : binary value of gray (only with GRAY_SEQ_BIN_MIRROR_EN defined)
//
// Optional feature macro: GRAY_SEQ_BIN_MIRROR_EN
// -----------------------------------------------------------------------------
module gray_sequencer
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] gray,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             wrap,
`ifdef GRAY_SEQ_BIN_MIRROR_EN
  output logic [WIDTH-1:0] bin_mirror,
`endif
  output logic             done
);

  localparam logic [WIDTH-1:0] BIN_MIN = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};

  state_t           state_r, state_nxt;
  logic [WIDTH-1:0] bin_r, bin_nxt;
  logic [WIDTH-1:0] gray_r, gray_nxt;
  logic             valid_r, valid_nxt;
  logic             busy_r, busy_nxt;
  logic             wrap_r, wrap_nxt;
  logic             done_r, done_nxt;
  logic             dir_r, dir_nxt;
  logic             mode_r, mode_nxt;
`ifdef GRAY_SEQ_BIN_MIRROR_EN
  logic [WIDTH-1:0] mirror_r, mirror_nxt;
`endif

  logic             load_s;
  logic             expire_s;
  logic             terminal_s;
  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] start_bin_s;

  gray_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .expire (expire_s)
  );

  // Counter step, terminal detection and start value, all direction dependent.
  always_comb begin
    if (dir_r) begin
      step_s     = bin_r + WIDTH'(1);
      terminal_s = (bin_r == BIN_MAX);
    end else begin
      step_s     = bin_r - WIDTH'(1);
      terminal_s = (bin_r == BIN_MIN);
    end
    if (dir) begin
      start_bin_s = BIN_MIN;
    end else begin
      start_bin_s = BIN_MAX;
    end
  end

  // Next-state and next-output logic. gray only reloads when a new code is
  // presented, so it keeps showing the last offered code through WAIT and
  // after an abort even though bin has already advanced.
  always_comb begin
    state_nxt = state_r;
    bin_nxt   = bin_r;
    gray_nxt  = gray_r;
    valid_nxt = valid_r;
    busy_nxt  = busy_r;
    dir_nxt   = dir_r;
    mode_nxt  = mode_r;
    wrap_nxt  = 1'b0;
    done_nxt  = 1'b0;
    load_s    = 1'b0;
`ifdef GRAY_SEQ_BIN_MIRROR_EN
    mirror_nxt = mirror_r;
`endif
    case (state_r)
      IDLE: begin
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        if (start && !stop) begin
          state_nxt = PRESENT;
          bin_nxt   = start_bin_s;
          gray_nxt  = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(start_bin_s)));
          dir_nxt   = dir;
          mode_nxt  = mode;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
`ifdef GRAY_SEQ_BIN_MIRROR_EN
          mirror_nxt = start_bin_s;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      PRESENT: begin
        if (ready) begin
          // Handshake: the transfer completes even if stop arrives with it.
          bin_nxt = step_s;
          if (stop) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
          end else if (terminal_s && mode_r) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT;
            valid_nxt = 1'b0;
            wrap_nxt  = terminal_s;
            load_s    = 1'b1;
          end
        end else if (stop) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
        end else begin
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      WAIT: begin
        if (stop) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
        end else if (expire_s) begin
          state_nxt = PRESENT;
          gray_nxt  = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_r)));
          valid_nxt = 1'b1;
`ifdef GRAY_SEQ_BIN_MIRROR_EN
          mirror_nxt = bin_r;
`endif
        end else begin
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      bin_r   <= {WIDTH{1'b0}};
      gray_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      wrap_r  <= 1'b0;
      done_r  <= 1'b0;
      dir_r   <= 1'b0;
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      bin_r   <= bin_nxt;
      gray_r  <= gray_nxt;
      valid_r <= valid_nxt;
      busy_r  <= busy_nxt;
      wrap_r  <= wrap_nxt;
      done_r  <= done_nxt;
      dir_r   <= dir_nxt;
      mode_r  <= mode_nxt;
    end
  end

`ifdef GRAY_SEQ_BIN_MIRROR_EN
  // Binary image of gray, loaded on the same edges as gray.
  always_ff @(posedge clk) begin
    if (rst) begin
      mirror_r <= {WIDTH{1'b0}};
    end else begin
      mirror_r <= mirror_nxt;
    end
  end

  assign bin_mirror = mirror_r;
`endif

  assign gray  = gray_r;
  assign valid = valid_r;
  assign busy  = busy_r;
  assign wrap  = wrap_r;
  assign done  = done_r;

endmodule
